req_ack_responder: RTL and testbench
====================================

REQ_ACK_RESPONDER -- requirements
Module: req_ack_responder

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the request payload width in bits.
REQ-002 Parameter DEPTH, default 4, SHALL set the request buffer depth; it SHALL be a power of two, 2..64.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req  input  1  request strobe from the initiator, sampled on each rising edge.
REQ-006 req_data  input  DATA_W  request payload, valid when req=1.
REQ-007 ack  output  1  registered accept pulse.
REQ-008 nack  output  1  registered reject pulse (buffer full).
REQ-009 out_valid  output  1  buffered request available downstream.
REQ-010 out_data  output  DATA_W  oldest buffered payload.
REQ-011 out_ready  input  1  downstream consumes the head entry when out_valid=1.
REQ-012 count  output  clog2(DEPTH)+1  current number of buffered entries.
REQ-013 drop_cnt  output  8  saturating count of rejected requests.

Function
REQ-014 A request SHALL be accepted at edge N when req=1 and either count<DEPTH or a pop occurs at the same edge.
REQ-015 For every accepted request at edge N, ack SHALL be 1 for exactly the cycle following edge N (req |=> ack); otherwise ack SHALL be 0.
REQ-016 For every rejected request at edge N, nack SHALL be 1 for exactly the cycle following edge N; ack and nack SHALL never both be 1.
REQ-017 Back-to-back requests SHALL produce back-to-back ack/nack pulses with no idle cycle inserted.
REQ-018 An accepted payload SHALL be written to the buffer tail at edge N; a rejected payload SHALL be discarded.
REQ-019 A pop SHALL occur at edge N when out_valid=1 and out_ready=1, and SHALL remove the head entry.
REQ-020 out_valid SHALL equal (count!=0); out_data SHALL present the head entry and SHALL be held stable while out_valid=1 and out_ready=0.
REQ-021 Pass-through latency: a request accepted at edge N into an empty buffer SHALL make out_valid=1 in the cycle following edge N, concurrent with ack.
REQ-022 Simultaneous push and pop at edge N SHALL leave count unchanged; this SHALL hold at count=DEPTH (full) and at count=0 is impossible since out_valid=0.
REQ-023 count SHALL increment on push-only, decrement on pop-only, and never exceed DEPTH or go below 0.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH with no loss or duplication of entries; FIFO order SHALL be preserved.
REQ-025 drop_cnt SHALL increment by 1 on each reject and SHALL saturate at 255.
REQ-026 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-027 req_data SHALL be ignored when req=0.

Reset
REQ-028 At any edge with rst_n=0: ack=0, nack=0, count=0, out_valid=0, drop_cnt=0, both pointers=0; buffer contents are don't-care.
REQ-029 A req sampled at an edge with rst_n=0 SHALL be neither accepted nor rejected and SHALL produce no ack/nack pulse.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries and abort any ack/nack pulse pending for the next cycle.
REQ-031 The first edge with rst_n=1 SHALL process req normally.

Verification
REQ-032 Single request: req=1 with req_data=0xA5 for one cycle, out_ready=1 -> ack=1 next cycle only, out_valid=1 with out_data=0xA5 in that cycle, count returns to 0 after the pop.
REQ-033 Fill and overflow (DEPTH=4, out_ready=0): 6 consecutive requests 0x01..0x06 -> 4 ack pulses then 2 nack pulses, count=4, drop_cnt=2; then out_ready=1 -> out_data 0x01,0x02,0x03,0x04 in order.
REQ-034 Full with simultaneous pop: count=4, req=1 and out_ready=1 at the same edge -> ack=1 (not nack), count stays 4, drop_cnt unchanged.
REQ-035 Wrap-around: 20 requests, payloads 0..19, with out_ready toggling 1,0,1,0 -> all 20 payloads acked and emitted in order, no nack.
REQ-036 Reset mid-stream: count=3, an accepted req at edge N, rst_n=0 at edge N+1 -> ack=0 following edge N+1, count=0, out_valid=0, drop_cnt=0.
REQ-037 Drop saturation: 300 requests with out_ready=0 after the buffer is full -> drop_cnt=255 and stays at 255.

Source files
------------

// File: rtl/req_ack_responder.sv
// Request buffer: accepts req into a DEPTH-entry FIFO with a registered ack/nack one cycle later.
// Head is visible the cycle after an accept; a full buffer rejects unless the head pops at the same edge.
module req_ack_responder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req,
    input  logic [DATA_W-1:0]        req_data,
    output logic                     ack,
    output logic                     nack,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [7:0]        drop_q, drop_d;
    logic              ack_q, ack_d;
    logic              nack_q, nack_d;
    logic              pop, push, accept;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    // A pop at the same edge frees the slot, so a full buffer can still accept.
    assign accept    = (count_q != FULL_CNT) | pop;
    assign push      = req & accept;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        ack_d    = push;
        nack_d   = req & ~accept;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (nack_d && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
            ack_q    <= ack_d;
            nack_q   <= nack_d;
        end
    end

    // Storage needs no reset; the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= req_data;
        end
    end

    assign out_data = mem_q[rd_ptr_q];
    assign ack      = ack_q;
    assign nack     = nack_q;
    assign count    = count_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench: stimulus queues expected ack/nack codes and accepted payloads;
// a negedge monitor retires them as the DUT presents responses and pops.
module tb_req_ack_responder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req = 1'b0;
    logic [7:0] req_data = 8'h00;
    logic       ack, nack, out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [2:0] count;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;

    logic [1:0] exp_resp_q [$];
    logic [7:0] exp_data_q [$];
    logic [1:0] e_resp;
    logic [7:0] e_data;

    localparam int NONE = 0;
    localparam int ACK  = 1;
    localparam int NACK = 2;

    req_ack_responder #(.DATA_W(8), .DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .nack      (nack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs and record what the DUT must answer for it.
    task automatic step(input logic r, input logic [7:0] d, input logic rdy, input int e);
        req       = r;
        req_data  = d;
        out_ready = rdy;
        if (e == ACK) begin
            exp_resp_q.push_back(2'b01);
            exp_data_q.push_back(d);
        end else if (e == NACK) begin
            exp_resp_q.push_back(2'b10);
        end
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (ack && nack) begin
            total++;
            bad++;
            $display("FAIL ack_and_nack: got ack=1 nack=1 expected at most one");
        end
        if (ack || nack) begin
            total++;
            if (exp_resp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_resp: got ack=%0d nack=%0d expected none", ack, nack);
            end else begin
                e_resp = exp_resp_q.pop_front();
                if ({nack, ack} !== e_resp) begin
                    bad++;
                    $display("FAIL resp: got {nack,ack}=%b expected %b", {nack, ack}, e_resp);
                end
            end
        end
        if (out_valid && out_ready && rst_n) begin
            total++;
            if (exp_data_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pop: got out_data=%0h expected no valid entry", out_data);
            end else begin
                e_data = exp_data_q.pop_front();
                if (out_data !== e_data) begin
                    bad++;
                    $display("FAIL pop_data: got %0h expected %0h", out_data, e_data);
                end
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_nack", nack, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_drop", drop_cnt, 0);
        rst_n = 1'b1;

        // Single request with pass-through
        step(1'b1, 8'hA5, 1'b1, ACK);
        chk("single_ack", ack, 1);
        chk("single_valid", out_valid, 1);
        chk("single_data", out_data, 8'hA5);
        chk("single_count", count, 1);
        step(1'b0, 8'h00, 1'b1, NONE);
        chk("single_ack_gone", ack, 0);
        chk("single_count0", count, 0);
        chk("single_valid0", out_valid, 0);

        // Fill and overflow
        for (int i = 1; i <= 6; i++) step(1'b1, 8'(i), 1'b0, (i <= 4) ? ACK : NACK);
        chk("ovf_count", count, 4);
        chk("ovf_drop", drop_cnt, 2);
        chk("ovf_hold_data", out_data, 8'h01);
        step(1'b0, 8'h00, 1'b0, NONE);
        chk("ovf_hold_data2", out_data, 8'h01);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, NONE);
        chk("ovf_drained", count, 0);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h10 + i), 1'b0, ACK);
        step(1'b1, 8'h14, 1'b1, ACK);
        chk("fullpop_ack", ack, 1);
        chk("fullpop_nack", nack, 0);
        chk("fullpop_count", count, 4);
        chk("fullpop_drop", drop_cnt, 2);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, NONE);
        chk("fullpop_drained", count, 0);

        // out_ready with empty buffer, payload with req=0
        step(1'b0, 8'hFF, 1'b1, NONE);
        step(1'b0, 8'hFF, 1'b1, NONE);
        chk("idle_count", count, 0);
        chk("idle_valid", out_valid, 0);

        // Wrap-around with out_ready toggling
        for (int i = 0; i < 6; i++) step(1'b1, 8'(i), (i % 2 == 0), ACK);
        chk("wrap_full", count, 4);
        for (int i = 6; i < 20; i++) begin
            step(1'b1, 8'(i), 1'b1, ACK);
            step(1'b0, 8'h00, 1'b0, NONE);
        end
        chk("wrap_count", count, 4);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, NONE);
        chk("wrap_drained", count, 0);
        chk("wrap_drop", drop_cnt, 2);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h31 + i), 1'b0, ACK);
        chk("mid_count3", count, 3);
        step(1'b1, 8'h34, 1'b0, ACK);
        rst_n    = 1'b0;
        req      = 1'b1;
        req_data = 8'h77;
        @(posedge clk);
        #1;
        exp_data_q.delete();
        chk("mid_ack", ack, 0);
        chk("mid_nack", nack, 0);
        chk("mid_count", count, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_drop", drop_cnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b1, 8'h55, 1'b0, ACK);
        chk("post_rst_ack", ack, 1);
        chk("post_rst_count", count, 1);
        step(1'b0, 8'h00, 1'b1, NONE);
        chk("post_rst_drained", count, 0);

        // Drop counter saturation
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h60 + i), 1'b0, ACK);
        for (int i = 0; i < 300; i++) step(1'b1, 8'(i), 1'b0, NACK);
        step(1'b0, 8'h00, 1'b0, NONE);
        chk("sat_drop", drop_cnt, 255);
        chk("sat_count", count, 4);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hEE, 1'b0, NACK);
        step(1'b0, 8'h00, 1'b0, NONE);
        chk("sat_hold", drop_cnt, 255);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, NONE);
        chk("sat_drained", count, 0);

        step(1'b0, 8'h00, 1'b0, NONE);
        step(1'b0, 8'h00, 1'b0, NONE);
        chk("resp_leftover", exp_resp_q.size(), 0);
        chk("data_leftover", exp_data_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
